uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Arbitrates two single-byte requesters onto one UART transmitter. Each
//   accepted byte is wrapped in a 4-byte frame:
//     byte0 = SYNC_BYTE
//     byte1 = {7'b0, src}
//     byte2 = payload
//     byte3 = byte0 ^ byte1 ^ byte2   (8-bit XOR checksum)
//   Bytes are launched one at a time with a single-cycle tx_start. The block
//   then waits for the transmitter to raise tx_busy (bounded by ACK_TIMEOUT)
//   and to drop it again before launching the next byte.
//
// Parameters:
//   SYNC_BYTE   - first byte of every frame
//   ACK_TIMEOUT - max cycles to wait for tx_busy to rise after tx_start
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   req_valid  in   [1:0] per-requester valid (held with data until accepted)
//   req_data0  in   [7:0] requester 0 payload
//   req_data1  in   [7:0] requester 1 payload
//   req_ready  out  [1:0] per-requester accept, only ever high in IDLE
//   tx_start   out  one-cycle byte launch
//   tx_data    out  [7:0] byte being sent, stable between launches
//   tx_busy    in   transmitter busy
//   busy       out  high whenever a frame is in progress
//   frame_done out  one-cycle pulse on frame completion
//   err        out  one-cycle pulse when a frame is aborted on timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  localparam int CNT_REQ = $clog2(ACK_TIMEOUT + 1);
  localparam int CNT_W   = (CNT_REQ > 4) ? CNT_REQ : 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last, last_nxt;       // requester granted most recently
  logic             src, src_nxt;
  logic [7:0]       payload, payload_nxt;
  logic [7:0]       txd, txd_nxt;
  logic [1:0]       grant;

  // Frame byte selector; byte3 is the carry-free XOR checksum.
  function automatic logic [7:0] frame_byte(input logic [1:0] i,
                                            input logic       s,
                                            input logic [7:0] p);
    logic [7:0] b1;
    b1 = {7'b0, s};
    case (i)
      2'd0:    frame_byte = SYNC_BYTE;
      2'd1:    frame_byte = b1;
      2'd2:    frame_byte = p;
      default: frame_byte = SYNC_BYTE ^ b1 ^ p;
    endcase
  endfunction

  // Round-robin: under contention the requester that did not win last time
  // is chosen. grant implies the matching valid bit, so |grant in IDLE is a
  // transfer.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    last_nxt    = last;
    src_nxt     = src;
    payload_nxt = payload;
    txd_nxt     = txd;
    req_ready   = 2'b00;
    tx_start    = 1'b0;
    frame_done  = 1'b0;
    err         = 1'b0;

    case (state)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          last_nxt    = grant[1];
          src_nxt     = grant[1];
          payload_nxt = grant[1] ? req_data1 : req_data0;
          idx_nxt     = 2'd0;
          txd_nxt     = SYNC_BYTE;
          state_nxt   = SEND;
        end
      end

      // Launch is held off while the transmitter is still busy (possible
      // right after our own reset, since the transmitter resets separately).
      SEND: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (cnt == CNT_MAX) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == 2'd3) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            txd_nxt   = frame_byte(idx + 2'd1, src, payload);
            state_nxt = SEND;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // While reset is asserted no handshake or pulse may escape, including
    // a frame_done/err that would otherwise coincide with the reset cycle.
    if (!rst) begin
      req_ready  = 2'b00;
      tx_start   = 1'b0;
      frame_done = 1'b0;
      err        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      cnt     <= '0;
      last    <= 1'b1;
      src     <= 1'b0;
      payload <= 8'h00;
      txd     <= 8'h00;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      src     <= src_nxt;
      payload <= payload_nxt;
      txd     <= txd_nxt;
    end
  end

  assign tx_data = txd;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. A transaction-level reference
// model (frame kept as a 4-entry byte array with a launch pointer and an
// acknowledge timer) predicts every output each cycle. A simple transmitter
// model drives tx_busy. Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 15;

  localparam int PH_IDLE   = 0;  // no frame in progress
  localparam int PH_LAUNCH = 1;  // next byte due for launch
  localparam int PH_RISE   = 2;  // launched, waiting for transmitter ack
  localparam int PH_FALL   = 3;  // transmitter sending, waiting for it to finish

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00;
  logic [7:0] req_data1 = 8'h00;
  logic       tx_busy = 1'b0;
  logic [1:0] req_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;
  logic       err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.SYNC_BYTE(SYNC), .ACK_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  int tests  = 0;
  int failed = 0;

  // environment
  bit         tx_dead    = 1'b0;
  int         busy_len   = 10;
  int         tx_cnt     = 0;
  bit         saw_start  = 1'b0;
  bit         hold_valid = 1'b0;
  bit         rand_mode  = 1'b0;
  logic [1:0] accepted   = 2'b00;

  // reference model
  int         m_phase;
  int         m_pos;
  int         m_wait;
  int         m_last;
  logic [7:0] m_frame [4];
  logic [7:0] m_txd;

  // monitors
  int         cyc = 0;
  logic [7:0] sent [$];
  int         n_start = 0, n_done = 0, n_err = 0;
  int         first_start_cyc = 0, err_cyc = 0;
  int         ready_in_busy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = PH_IDLE;
    m_pos   = 0;
    m_wait  = 0;
    m_last  = 1;
    m_txd   = 8'h00;
  endtask

  task automatic clear_mon();
    sent.delete();
    n_start = 0; n_done = 0; n_err = 0;
    ready_in_busy = 0;
  endtask

  // One clock cycle: check outputs against the model, advance the model,
  // then update the transmitter and requester stimulus just after the edge.
  // Returns at the following falling edge.
  task automatic step();
    int         g;
    logic [1:0] e_ready;
    logic       e_start, e_done, e_err, e_busy;
    #1;
    g = -1;
    e_ready = 2'b00; e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
    e_busy = (m_phase != PH_IDLE);
    case (m_phase)
      PH_IDLE: begin
        if (req_valid == 2'b11) g = 1 - m_last;
        else if (req_valid[0])  g = 0;
        else if (req_valid[1])  g = 1;
        if (g >= 0) e_ready[g] = 1'b1;
      end
      PH_LAUNCH: e_start = !tx_busy;
      PH_RISE:   e_err   = !tx_busy && (m_wait == TMO);
      PH_FALL:   e_done  = !tx_busy && (m_pos == 3);
      default: ;
    endcase
    if (!rst) begin
      e_ready = 2'b00; e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end

    chk("req_ready",  32'(req_ready),  32'(e_ready));
    chk("tx_start",   32'(tx_start),   32'(e_start));
    chk("tx_data",    32'(tx_data),    32'(m_txd));
    chk("busy",       32'(busy),       32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("err",        32'(err),        32'(e_err));
    chk("pacing",     32'(tx_start & tx_busy), 32'd0);

    if (tx_start) begin
      sent.push_back(tx_data);
      n_start++;
      if (n_start == 1) first_start_cyc = cyc;
    end
    if (frame_done) n_done++;
    if (err) begin n_err++; err_cyc = cyc; end
    if (busy && (req_ready != 2'b00)) ready_in_busy++;
    saw_start = tx_start;

    accepted = 2'b00;
    if (!rst) begin
      m_reset();
    end else begin
      case (m_phase)
        PH_IDLE: if (g >= 0) begin
          m_last     = g;
          m_frame[0] = SYNC;
          m_frame[1] = 8'(g);
          m_frame[2] = (g == 1) ? req_data1 : req_data0;
          m_frame[3] = m_frame[0] ^ m_frame[1] ^ m_frame[2];
          m_pos      = 0;
          m_txd      = m_frame[0];
          m_phase    = PH_LAUNCH;
          accepted[g] = 1'b1;
        end
        PH_LAUNCH: if (!tx_busy) begin
          m_phase = PH_RISE;
          m_wait  = 0;
        end
        PH_RISE: begin
          if (tx_busy)            m_phase = PH_FALL;
          else if (m_wait == TMO) m_phase = PH_IDLE;
          else                    m_wait++;
        end
        PH_FALL: if (!tx_busy) begin
          if (m_pos == 3) m_phase = PH_IDLE;
          else begin
            m_pos++;
            m_txd   = m_frame[m_pos];
            m_phase = PH_LAUNCH;
          end
        end
        default: ;
      endcase
    end

    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      busy_len = $urandom_range(12, 1);
      if ($urandom_range(63) == 0) tx_dead = !tx_dead;
    end
    if (tx_dead)        tx_cnt = 0;
    else if (saw_start) tx_cnt = busy_len;
    else if (tx_cnt > 0) tx_cnt--;
    tx_busy = (tx_cnt > 0);
    if (!hold_valid) req_valid = req_valid & ~accepted;
    if (rand_mode) begin
      rst = ($urandom_range(199) != 0);
      if (!req_valid[0] && $urandom_range(3) == 0) begin
        req_valid[0] = 1'b1;
        req_data0    = 8'($urandom);
      end
      if (!req_valid[1] && $urandom_range(3) == 0) begin
        req_valid[1] = 1'b1;
        req_data1    = 8'($urandom);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_bytes [4];
    m_reset();
    @(negedge clk);

    // ---- reset state: requests present but nothing may be granted ----
    req_valid = 2'b11;
    req_data0 = 8'h5A;
    req_data1 = 8'hC3;
    step();
    step();
    #1;
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data),   32'h00);
    chk("rst_busy",    32'(busy),      32'd0);

    // ---- single frame ----
    rst = 1'b1;
    req_valid = 2'b01;
    req_data0 = 8'h3C;
    busy_len  = 10;
    clear_mon();
    for (int k = 0; k < 200 && n_done == 0; k++) step();
    repeat (3) step();
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h3C; exp_bytes[3] = 8'h99;
    chk("single_nbytes", 32'(sent.size()), 32'd4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("single_byte", 32'(sent[i]), 32'(exp_bytes[i]));
    chk("single_starts", 32'(n_start), 32'd4);
    chk("single_done",   32'(n_done),  32'd1);

    // ---- contention: both held, alternation from requester 0 ----
    do_reset(1);
    req_valid  = 2'b11;
    req_data0  = 8'h11;
    req_data1  = 8'h22;
    hold_valid = 1'b1;
    clear_mon();
    for (int k = 0; k < 400 && n_done < 4; k++) step();
    req_valid  = 2'b00;
    hold_valid = 1'b0;
    repeat (3) step();
    chk("cont_nbytes", 32'(sent.size()), 32'd16);
    for (int f = 0; f < 4 && (4 * f + 3) < sent.size(); f++) begin
      chk("cont_sync", 32'(sent[4*f]),   32'hA5);
      chk("cont_src",  32'(sent[4*f+1]), 32'(f % 2));
      chk("cont_pay",  32'(sent[4*f+2]), (f % 2) ? 32'h22 : 32'h11);
      chk("cont_csum", 32'(sent[4*f+3]), (f % 2) ? 32'h86 : 32'hB4);
    end

    // ---- timeout: transmitter never acknowledges ----
    tx_dead   = 1'b1;
    req_valid = 2'b01;
    req_data0 = 8'($urandom);
    clear_mon();
    for (int k = 0; k < 100 && n_err == 0; k++) step();
    repeat (4) step();
    chk("tmo_err",    32'(n_err),                     32'd1);
    chk("tmo_delay",  32'(err_cyc - first_start_cyc), 32'd16);
    chk("tmo_starts", 32'(n_start),                   32'd1);
    chk("tmo_done",   32'(n_done),                    32'd0);
    #1;
    chk("tmo_idle",   32'(busy),                      32'd0);
    tx_dead = 1'b0;

    // ---- reset mid-frame during byte 2 ----
    req_valid = 2'b10;
    req_data1 = 8'($urandom);
    clear_mon();
    for (int k = 0; k < 100 && sent.size() < 3; k++) step();
    repeat (2) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    req_valid = 2'b11;
    req_data0 = 8'($urandom);
    req_data1 = 8'($urandom);
    clear_mon();
    for (int k = 0; k < 200 && n_done == 0; k++) step();
    chk("mid_done", 32'(n_done), 32'd1);
    if (sent.size() >= 2) begin
      chk("mid_first_sync", 32'(sent[0]), 32'hA5);
      chk("mid_first_src",  32'(sent[1]), 32'h00);
    end else begin
      chk("mid_nbytes", 32'(sent.size()), 32'd4);
    end
    for (int k = 0; k < 200 && busy; k++) step();

    // ---- late valid: requester 1 appears mid-frame ----
    do_reset(1);
    req_valid = 2'b01;
    req_data0 = 8'($urandom);
    clear_mon();
    for (int k = 0; k < 100 && n_start < 2; k++) step();
    req_valid[1] = 1'b1;
    req_data1    = 8'($urandom);
    for (int k = 0; k < 200 && n_done == 0; k++) step();
    #1;
    chk("late_grant",    32'(req_ready),     32'b10);
    chk("late_no_ready", 32'(ready_in_busy), 32'd0);
    for (int k = 0; k < 200 && n_done < 2; k++) step();
    chk("late_frames",   32'(n_done),        32'd2);
    repeat (2) step();

    // ---- randomized traffic ----
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    tx_dead   = 1'b0;
    rst       = 1'b1;
    req_valid = 2'b00;
    repeat (100) step();
    #1;
    chk("drain_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
